// File: rtl/mux8_sched_pkg.sv
// mux8_sched_pkg: shared constants, FSM state type and the round-robin
// search helper used by the mux8_sched scheduler and its picker.
package mux8_sched_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    // Result of one arbitration: winning index plus whether anyone asked.
    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Round-robin search over mask starting at ptr, wrapping 7 -> 0.
    // Walks from the farthest offset down to offset 0 so the requester
    // closest to ptr is written last and wins.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] mask,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            r;
        logic [SEL_W-1:0] cand;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (mask[cand]) begin
                r.found = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_sched_if.sv
// mux8_sched_if: requester-side bundle (req/in), downstream handshake
// (y/valid/ready/last) and the grant/select status of the scheduler.
// master = requester/downstream environment, slave = the scheduler.
interface mux8_sched_if;
    import mux8_sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] in;
    logic             ready;
    logic             y;
    logic             valid;
    logic [SEL_W-1:0] sel;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic             last;

    modport master (
        output req, in, ready,
        input  y, valid, sel, gnt, busy, last
    );

    modport slave (
        input  req, in, ready,
        output y, valid, sel, gnt, busy, last
    );

endinterface

// File: rtl/mux8_sched_rr_pick8.sv
// rr_pick8: combinational 8-way arbiter.
// Build option MUX8_SCHED_FIXED_PRIO_EN: when defined the pointer is
// ignored and the lowest requesting index always wins.
module rr_pick8 import mux8_sched_pkg::*; (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    pick_t pick;

`ifdef MUX8_SCHED_FIXED_PRIO_EN
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    // Fixed priority: search always starts at requester 0.
    always_comb begin
        pick = rr_pick(req, '0);
    end
`else
    // Round-robin: search starts at the supplied pointer.
    always_comb begin
        pick = rr_pick(req, ptr);
    end
`endif

    assign idx   = pick.idx;
    assign found = pick.found;

endmodule

// File: rtl/mux8x1.sv
// mux8x1: the shared 8:1 serial data mux. Purely combinational.
module mux8x1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       y
);

    assign y = in[sel];

endmodule

// File: rtl/mux8_sched.sv
// mux8_sched: frame-based round-robin scheduler in front of mux8x1.
// Grants one requester for FRAME_LEN bits, owns the mux select and
// presents the selected bit downstream with valid/ready.
// Build option MUX8_SCHED_FIXED_PRIO_EN: fixed priority (lowest index
// wins, pointer held at 0) instead of round-robin.
module mux8_sched import mux8_sched_pkg::*; #(
    parameter int FRAME_LEN = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mux8_sched_if.slave  bus
);

    localparam int               CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

`ifdef MUX8_SCHED_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    sched_state_t     state;
    logic             busy_q;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] sel_q;
    logic [N_REQ-1:0] gnt_q;
    logic [CNT_W-1:0] cnt;

    logic             valid_c;
    logic             last_c;
    logic             xfer;
    logic             frame_end;
    logic             mux_y;
    logic [SEL_W-1:0] sel_inc;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;

    // Beat qualification: a beat is valid only while the granted
    // requester keeps its request up; it transfers when downstream is ready.
    assign valid_c   = (state == BURST) && bus.req[sel_q];
    assign last_c    = valid_c && (cnt == CNT_LAST);
    assign xfer      = valid_c && bus.ready;
    assign frame_end = xfer && last_c;

    // In BURST the only arbitration that matters is at end of frame, where
    // the search starts just past the current owner; that is the value ptr
    // is about to take, so the picker sees it in the same cycle.
    assign sel_inc  = sel_q + SEL_W'(1);
    assign pick_ptr = (state == BURST) ? sel_inc : ptr;

    rr_pick8 u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .idx   (win_idx),
        .found (win_found)
    );

    // Scheduler FSM: grant, frame counting, pointer rotation and abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            ptr    <= '0;
            sel_q  <= '0;
            gnt_q  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state  <= BURST;
                        busy_q <= 1'b1;
                        sel_q  <= win_idx;
                        gnt_q  <= sel_onehot(win_idx);
                        cnt    <= '0;
                    end else begin
                        gnt_q  <= '0;
                    end
                end
                BURST: begin
                    if (!bus.req[sel_q]) begin
                        // Owner dropped mid-frame: discard the partial frame.
                        if (!FIXED_PRIO) ptr <= sel_inc;
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        gnt_q  <= '0;
                    end else if (frame_end) begin
                        if (!FIXED_PRIO) ptr <= sel_inc;
                        cnt <= '0;
                        if (win_found) begin
                            // Back-to-back frame, no bubble.
                            sel_q <= win_idx;
                            gnt_q <= sel_onehot(win_idx);
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            gnt_q  <= '0;
                        end
                    end else if (xfer) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    gnt_q  <= '0;
                end
            endcase
        end
    end

    mux8x1 u_mux (
        .in  (bus.in),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign bus.y     = mux_y & valid_c;
    assign bus.valid = valid_c;
    assign bus.last  = last_c;
    assign bus.sel   = sel_q;
    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux8_sched.sv
// tb_mux8_sched: directed bench for mux8_sched (FRAME_LEN=8 main instance,
// FRAME_LEN=1 side instance). Inputs change and outputs are sampled on the
// falling edge; the design registers on the rising edge.
module tb_mux8_sched;
    import mux8_sched_pkg::*;

`ifdef MUX8_SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] pat;
    logic [7:0] din;
    logic       b;
    int         exp_sel;

    always #5 clk = ~clk;

    mux8_sched_if bus ();
    mux8_sched_if bus1 ();

    mux8_sched #(.FRAME_LEN(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mux8_sched #(.FRAME_LEN(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.in     = '0;
        bus.ready  = 1'b1;
        bus1.req   = '0;
        bus1.in    = '0;
        bus1.ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int rr_exp(input int f);
        return FIXED ? 0 : (f % 8);
    endfunction

    initial begin
        // ---------------- reset with all requesting ----------------
        rst_n      = 1'b0;
        bus.req    = 8'hFF;
        bus.in     = 8'hFF;
        bus.ready  = 1'b1;
        bus1.req   = '0;
        bus1.in    = '0;
        bus1.ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt",   bus.gnt,   8'h00);
        chk("rst_sel",   bus.sel,   3'd0);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_y",     bus.y,     1'b0);
        chk("rst_busy",  bus.busy,  1'b0);
        chk("rst_last",  bus.last,  1'b0);
        chk("rst_cnt",   dut.cnt,   0);
        rst_n   = 1'b1;
        bus.req = '0;

        // ---------------- single requester ----------------
        pat = 8'b10110010;
        @(negedge clk);
        bus.req = 8'h04;
        bus.in  = 8'hFF;
        #1;
        chk("single_idle_valid", bus.valid, 1'b0);
        chk("single_idle_busy",  bus.busy,  1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            b      = pat[7-k];
            bus.in = b ? 8'h04 : 8'hFB;
            #1;
            if (k == 0) begin
                chk("single_gnt", bus.gnt, 8'h04);
                chk("single_sel", bus.sel, 3'd2);
            end
            chk("single_valid", bus.valid, 1'b1);
            chk("single_y",     bus.y,     b);
            chk("single_last",  bus.last,  (k == 7));
        end
        @(negedge clk);
        bus.req = '0;
        bus.in  = 8'hFF;
        #1;
        chk("single_drop_valid", bus.valid, 1'b0);
        chk("single_drop_y",     bus.y,     1'b0);
        @(negedge clk);
        #1;
        chk("single_end_busy", bus.busy, 1'b0);
        chk("single_end_gnt",  bus.gnt,  8'h00);

        // ---------------- round-robin, all requesting ----------------
        do_reset();
        @(negedge clk);
        bus.req = 8'hFF;
        #1;
        chk("rr_idle_valid", bus.valid, 1'b0);
        for (int f = 0; f < 9; f++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                din    = 8'(37 * (f * 8 + k) + 11);
                bus.in = din;
                exp_sel = rr_exp(f);
                #1;
                if (k == 0) chk("rr_gnt", bus.gnt, 8'(1) << exp_sel);
                chk("rr_sel",   bus.sel,   exp_sel);
                chk("rr_valid", bus.valid, 1'b1);
                chk("rr_busy",  bus.busy,  1'b1);
                chk("rr_last",  bus.last,  (k == 7));
                chk("rr_y",     bus.y,     din[exp_sel]);
            end
        end
        @(negedge clk);
        bus.req = '0;
        #1;
        chk("rr_drop_valid", bus.valid, 1'b0);

        // ---------------- backpressure ----------------
        do_reset();
        @(negedge clk);
        bus.req = 8'h04;
        bus.in  = 8'hFF;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            bus.ready = (c % 2 == 0);
            #1;
            if (c == 0) chk("bp_sel", bus.sel, 3'd2);
            chk("bp_gnt",   bus.gnt,   8'h04);
            chk("bp_cnt",   dut.cnt,   (c + 1) / 2);
            chk("bp_valid", bus.valid, 1'b1);
            chk("bp_last",  bus.last,  (c >= 13));
        end
        @(negedge clk);
        bus.req   = '0;
        bus.ready = 1'b1;
        #1;
        chk("bp_drop_valid", bus.valid, 1'b0);

        // ---------------- abort ----------------
        do_reset();
        @(negedge clk);
        bus.req = 8'h28;
        bus.in  = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (c == 0) chk("abort_sel", bus.sel, 3'd3);
            chk("abort_gnt",   bus.gnt,   8'h08);
            chk("abort_valid", bus.valid, 1'b1);
        end
        @(negedge clk);
        bus.req = 8'h20;
        #1;
        chk("abort_cyc_valid", bus.valid, 1'b0);
        chk("abort_cyc_y",     bus.y,     1'b0);
        chk("abort_cyc_last",  bus.last,  1'b0);
        chk("abort_cyc_cnt",   dut.cnt,   3);
        @(negedge clk);
        #1;
        chk("abort_idle_busy", bus.busy, 1'b0);
        chk("abort_idle_gnt",  bus.gnt,  8'h00);
        chk("abort_idle_cnt",  dut.cnt,  0);
        @(negedge clk);
        #1;
        chk("abort_next_gnt",   bus.gnt,   8'h20);
        chk("abort_next_sel",   bus.sel,   3'd5);
        chk("abort_next_valid", bus.valid, 1'b1);

        // ---------------- reset mid-burst ----------------
        do_reset();
        @(negedge clk);
        bus.req = 8'h04;
        bus.in  = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("midrst_valid", bus.valid, 1'b1);
            chk("midrst_sel",   bus.sel,   3'd2);
            if (c == 3) rst_n = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("midrst_gnt",   bus.gnt,   8'h00);
        chk("midrst_sel0",  bus.sel,   3'd0);
        chk("midrst_busy",  bus.busy,  1'b0);
        chk("midrst_valid0", bus.valid, 1'b0);
        chk("midrst_y",     bus.y,     1'b0);
        chk("midrst_last",  bus.last,  1'b0);
        rst_n   = 1'b1;
        bus.req = 8'h80;
        @(negedge clk);
        #1;
        chk("midrst_next_gnt", bus.gnt, 8'h80);
        chk("midrst_next_sel", bus.sel, 3'd7);
        bus.req = '0;

        // ---------------- FRAME_LEN = 1 ----------------
        do_reset();
        @(negedge clk);
        bus1.req = 8'h06;
        bus1.in  = 8'h02;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_sel = FIXED ? 1 : ((c % 2 == 0) ? 1 : 2);
            #1;
            chk("f1_sel",   bus1.sel,   exp_sel);
            chk("f1_gnt",   bus1.gnt,   8'(1) << exp_sel);
            chk("f1_valid", bus1.valid, 1'b1);
            chk("f1_last",  bus1.last,  1'b1);
            chk("f1_y",     bus1.y,     (exp_sel == 1));
        end
        bus1.req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
